// File: rtl/nettlp_cmd_init.sv
// nettlp_cmd_init: programs the adapter network registers through the command FIFO
// pair, reads every register back (MAGIC first) and reports pass or the first error.
package nettlp_cmd_pkg;
  localparam logic [3:0] NETTLP_OPC_REG_RD = 4'h1;
  localparam logic [3:0] NETTLP_OPC_REG_WR = 4'h2;

  localparam logic [7:0] NETTLP_REG_MAGIC       = 8'd0;
  localparam logic [7:0] NETTLP_REG_DSTMAC_LOW  = 8'd1;
  localparam logic [7:0] NETTLP_REG_DSTMAC_HIGH = 8'd2;
  localparam logic [7:0] NETTLP_REG_SRCMAC_LOW  = 8'd3;
  localparam logic [7:0] NETTLP_REG_SRCMAC_HIGH = 8'd4;
  localparam logic [7:0] NETTLP_REG_DSTIP       = 8'd5;
  localparam logic [7:0] NETTLP_REG_SRCIP       = 8'd6;
  localparam logic [7:0] NETTLP_REG_DSTPORT     = 8'd7;
  localparam logic [7:0] NETTLP_REG_SRCPORT     = 8'd8;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [7:0]  dwaddr;
    logic [31:0] data;
  } FIFO_NETTLP_CMD_T;
endpackage

module nettlp_cmd_init
  import nettlp_cmd_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] MAGIC_EXPECT   = 32'h67452301
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [47:0]      cfg_dstmac,
  input  logic [47:0]      cfg_srcmac,
  input  logic [31:0]      cfg_dstip,
  input  logic [31:0]      cfg_srcip,
  input  logic [15:0]      cfg_dstport,
  input  logic [15:0]      cfg_srcport,
  output logic             fifo_req_wr_en,
  input  logic             fifo_req_full,
  output FIFO_NETTLP_CMD_T fifo_req_din,
  output logic             fifo_rsp_rd_en,
  input  logic             fifo_rsp_empty,
  input  FIFO_NETTLP_CMD_T fifo_rsp_dout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_mismatch,
  output logic             err_timeout,
  output logic [3:0]       err_step
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, DONE} state_t;

  state_t           state;
  logic [3:0]       idx;
  logic [CNT_W-1:0] wait_cnt;
  logic             rsp_skip;
  logic [47:0]      dstmac_q, srcmac_q;
  logic [31:0]      dstip_q, srcip_q;
  logic [15:0]      dstport_q, srcport_q;

  logic [2:0]       ent_sel;
  logic [7:0]       ent_addr;
  logic [31:0]      ent_data;
  logic [7:0]       rd_addr;
  logic [31:0]      rd_expect;
  logic             rsp_valid;
  logic             rsp_match;
  logic             rsp_opcode_unused;

  function automatic logic [31:0] swap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [31:0] mac_high(input logic [47:0] m);
    return {m[39:32], m[47:40], 16'h0000};
  endfunction

  function automatic logic [31:0] port_word(input logic [15:0] p);
    return {p[7:0], p[15:8], 16'h0000};
  endfunction

  // Read index i>0 revisits write entry i-1, so one table serves both lists.
  always_comb begin
    ent_sel  = (state == WR_ISSUE) ? idx[2:0] : 3'(idx - 4'd1);
    ent_addr = 8'd0;
    ent_data = 32'd0;
    case (ent_sel)
      3'd0: begin ent_addr = NETTLP_REG_DSTMAC_LOW;  ent_data = swap32(dstmac_q[31:0]); end
      3'd1: begin ent_addr = NETTLP_REG_DSTMAC_HIGH; ent_data = mac_high(dstmac_q);     end
      3'd2: begin ent_addr = NETTLP_REG_SRCMAC_LOW;  ent_data = swap32(srcmac_q[31:0]); end
      3'd3: begin ent_addr = NETTLP_REG_SRCMAC_HIGH; ent_data = mac_high(srcmac_q);     end
      3'd4: begin ent_addr = NETTLP_REG_DSTIP;       ent_data = swap32(dstip_q);        end
      3'd5: begin ent_addr = NETTLP_REG_SRCIP;       ent_data = swap32(srcip_q);        end
      3'd6: begin ent_addr = NETTLP_REG_DSTPORT;     ent_data = port_word(dstport_q);   end
      default: begin ent_addr = NETTLP_REG_SRCPORT;  ent_data = port_word(srcport_q);   end
    endcase
  end

  assign rd_addr   = (idx == 4'd0) ? NETTLP_REG_MAGIC : ent_addr;
  assign rd_expect = (idx == 4'd0) ? MAGIC_EXPECT : ent_data;

  // The FWFT FIFO needs a cycle to present the next word after each pop.
  assign rsp_valid         = !fifo_rsp_empty && !rsp_skip;
  assign rsp_match         = (fifo_rsp_dout.dwaddr == rd_addr) && (fifo_rsp_dout.data == rd_expect);
  assign rsp_opcode_unused = ^fifo_rsp_dout.opcode;

  assign fifo_req_wr_en = !rst && !fifo_req_full && ((state == WR_ISSUE) || (state == RD_ISSUE));
  assign fifo_rsp_rd_en = !rst && rsp_valid && ((state == IDLE) || (state == RD_WAIT));

  always_comb begin
    fifo_req_din = '0;
    if (!rst && state == WR_ISSUE) begin
      fifo_req_din.opcode = NETTLP_OPC_REG_WR;
      fifo_req_din.dwaddr = ent_addr;
      fifo_req_din.data   = ent_data;
    end else if (!rst && state == RD_ISSUE) begin
      fifo_req_din.opcode = NETTLP_OPC_REG_RD;
      fifo_req_din.dwaddr = rd_addr;
      fifo_req_din.data   = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= 4'd0;
      wait_cnt     <= '0;
      rsp_skip     <= 1'b0;
      dstmac_q     <= 48'd0;
      srcmac_q     <= 48'd0;
      dstip_q      <= 32'd0;
      srcip_q      <= 32'd0;
      dstport_q    <= 16'd0;
      srcport_q    <= 16'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_mismatch <= 1'b0;
      err_timeout  <= 1'b0;
      err_step     <= 4'd0;
    end else begin
      rsp_skip <= fifo_rsp_rd_en;
      unique case (state)
        IDLE: begin
          if (start) begin
            dstmac_q     <= cfg_dstmac;
            srcmac_q     <= cfg_srcmac;
            dstip_q      <= cfg_dstip;
            srcip_q      <= cfg_srcip;
            dstport_q    <= cfg_dstport;
            srcport_q    <= cfg_srcport;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_mismatch <= 1'b0;
            err_timeout  <= 1'b0;
            err_step     <= 4'd0;
            busy         <= 1'b1;
            idx          <= 4'd0;
            state        <= WR_ISSUE;
          end
        end
        WR_ISSUE: begin
          if (!fifo_req_full) begin
            if (idx == 4'd7) begin
              idx   <= 4'd0;
              state <= RD_ISSUE;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        RD_ISSUE: begin
          if (!fifo_req_full) begin
            wait_cnt <= '0;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rsp_valid) begin
            if (!rsp_match) begin
              err_mismatch <= 1'b1;
              err_step     <= idx;
              state        <= DONE;
            end else if (idx == 4'd8) begin
              state <= DONE;
            end else begin
              idx   <= idx + 4'd1;
              state <= RD_ISSUE;
            end
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            err_timeout <= 1'b1;
            err_step    <= idx;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= !(err_mismatch || err_timeout);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
